// File: rtl/core_sequencer_pkg.sv
// Shared RV32I control definitions: opcode constants, sequencer state, trap cause and PC-select encodings.
// Used by the sequencer, decoder and datapath.
package core_sequencer_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Explicit encodings keep the state values stable for the legacy debug taps.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      TRAP_NONE    = 2'd0,
      TRAP_SYSTEM  = 2'd1,
      TRAP_ILLEGAL = 2'd2,
      TRAP_TIMEOUT = 2'd3
   } trap_cause_t;

   typedef enum logic [1:0] {
      PC_PLUS4   = 2'd0,
      PC_PLUS_IMM = 2'd1,
      PC_ALU     = 2'd2
   } pc_sel_t;

   function automatic logic is_base_opcode(input logic [6:0] op);
      logic hit;
      hit = 1'b0;
      case (op)
         OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
         OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

   function automatic pc_sel_t exec_pc_sel(input logic [6:0] op, input logic taken);
      pc_sel_t sel;
      sel = PC_PLUS4;
      case (op)
         OPC_JAL:    sel = PC_PLUS_IMM;
         OPC_BRANCH: sel = taken ? PC_PLUS_IMM : PC_PLUS4;
         OPC_JALR:   sel = PC_ALU;
         default:    sel = PC_PLUS4;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/core_sequencer_bus_wait_timer.sv
// Counts consecutive wait cycles of a memory handshake; expired flags the wait
// cycle that reaches MEM_TIMEOUT.
module bus_wait_timer #(
   parameter int unsigned TMR_W       = 8,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam logic [TMR_W-1:0] LAST_WAIT = TMR_W'(MEM_TIMEOUT - 1);

   logic [TMR_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   // Count holds the waits already seen, so this cycle is wait number count+1.
   assign expired = inc && (count == LAST_WAIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with imem/dmem
// handshakes, gated regfile/PC writes, halt on SYSTEM, illegal opcode or bus timeout.
module core_sequencer
   import core_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TMR_W       = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             ir_we,
   input  logic [6:0]       opcode,
   input  logic             dec_we3,
   input  logic             dec_wem,
   input  logic             dec_load,
   input  logic             branch_taken,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             rf_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             halted,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retired
);

   state_t      state, state_nxt;
   trap_cause_t trap_q, trap_nxt;
   pc_sel_t     pc_sel_q;
   logic        tmr_inc;
   logic        tmr_expired;

   // Any cycle that is not a wait is either a state exit or outside FETCH/MEM,
   // so clearing on !inc also clears on every state entry.
   assign tmr_inc = ((state == ST_FETCH) && !imem_ready) ||
                    ((state == ST_MEM)   && !dmem_ready);

   bus_wait_timer #(
      .TMR_W      (TMR_W),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (!tmr_inc),
      .inc    (tmr_inc),
      .expired(tmr_expired)
   );

   always_comb begin
      state_nxt = state;
      trap_nxt  = trap_q;
      case (state)
         ST_FETCH: begin
            if (imem_ready) begin
               state_nxt = ST_DECODE;
            end else if (tmr_expired) begin
               state_nxt = ST_HALT;
               trap_nxt  = TRAP_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (opcode == OPC_SYSTEM) begin
               state_nxt = ST_HALT;
               trap_nxt  = TRAP_SYSTEM;
            end else if (!is_base_opcode(opcode)) begin
               state_nxt = ST_HALT;
               trap_nxt  = TRAP_ILLEGAL;
            end else begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt = (dec_load || dec_wem) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            if (dmem_ready) begin
               state_nxt = ST_WB;
            end else if (tmr_expired) begin
               state_nxt = ST_HALT;
               trap_nxt  = TRAP_TIMEOUT;
            end
         end
         ST_WB:   state_nxt = ST_FETCH;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_FETCH;
         trap_q   <= TRAP_NONE;
         pc_sel_q <= PC_PLUS4;
         retired  <= '0;
      end else begin
         state  <= state_nxt;
         trap_q <= trap_nxt;
         if (state == ST_EXEC) begin
            pc_sel_q <= exec_pc_sel(opcode, branch_taken);
         end
         if (state == ST_WB) begin
            retired <= retired + 1'b1;
         end
      end
   end

   assign imem_req   = (state == ST_FETCH);
   assign ir_we      = imem_req && imem_ready;
   assign dmem_req   = (state == ST_MEM);
   assign dmem_we    = dmem_req && dec_wem;
   assign rf_we      = (state == ST_WB) && dec_we3 && !dec_wem;
   assign pc_we      = (state == ST_WB);
   assign pc_sel     = pc_sel_q;
   assign halted     = (state == ST_HALT);
   assign trap_cause = trap_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: table of single-instruction vectors plus
// hand-written timeout, trap and reset sequences.
module tb_core_sequencer;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ready, ir_we;
   logic [6:0]  opcode;
   logic        dec_we3, dec_wem, dec_load, branch_taken;
   logic        dmem_req, dmem_we, dmem_ready;
   logic        rf_we, pc_we, halted;
   logic [1:0]  pc_sel, trap_cause;
   logic [31:0] retired;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_retired = 0;

   always #5 clk = ~clk;

   core_sequencer #(
      .MEM_TIMEOUT(TO),
      .TMR_W      (8),
      .CNT_W      (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_ready  (imem_ready),
      .ir_we       (ir_we),
      .opcode      (opcode),
      .dec_we3     (dec_we3),
      .dec_wem     (dec_wem),
      .dec_load    (dec_load),
      .branch_taken(branch_taken),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_ready  (dmem_ready),
      .rf_we       (rf_we),
      .pc_we       (pc_we),
      .pc_sel      (pc_sel),
      .halted      (halted),
      .trap_cause  (trap_cause),
      .retired     (retired)
   );

   typedef struct {
      string      name;
      logic [6:0] opc;
      logic       we3, wem, load, taken;
      int         fwait, mwait;
      logic [1:0] exp_sel;
      logic       exp_rf;
      int         exp_lat, exp_dcyc;
      logic       exp_dwe;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Leaves the bench at a falling edge with the DUT in FETCH and reset released.
   task automatic do_reset();
      reset = 1'b1;
      imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0;
      dec_we3 = 1'b0; dec_wem = 1'b0; dec_load = 1'b0; branch_taken = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_retired = 0;
   endtask

   task automatic run_vec(input vec_t v);
      int   fwait, mwait, lat, dcyc, ir_cyc;
      logic got_ir, stray_rf;
      fwait = v.fwait; mwait = v.mwait; lat = 0; dcyc = 0; ir_cyc = 0;
      got_ir = 1'b0; stray_rf = 1'b0;
      opcode = v.opc; dec_we3 = v.we3; dec_wem = v.wem; dec_load = v.load;
      branch_taken = v.taken;
      for (int c = 1; c <= 30; c++) begin
         imem_ready = !got_ir && (fwait == 0);
         dmem_ready = (mwait == 0);
         #1;
         if (imem_req && !imem_ready && fwait > 0) fwait--;
         if (ir_we) begin
            got_ir = 1'b1;
            ir_cyc = c;
         end
         if (dmem_req) begin
            dcyc++;
            check({v.name, " dmem_we"}, 32'(dmem_we), 32'(v.exp_dwe));
            if (!dmem_ready && mwait > 0) mwait--;
         end
         if (pc_we) begin
            lat = c;
            check({v.name, " pc_sel"}, 32'(pc_sel), 32'(v.exp_sel));
            check({v.name, " rf_we"}, 32'(rf_we), 32'(v.exp_rf));
            check({v.name, " retired"}, retired, 32'(exp_retired));
            break;
         end
         if (rf_we) stray_rf = 1'b1;
         if (halted) break;
         @(negedge clk);
      end
      check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
      check({v.name, " ir_we cycle"}, 32'(ir_cyc), 32'(v.fwait + 1));
      check({v.name, " dmem_req cycles"}, 32'(dcyc), 32'(v.exp_dcyc));
      check({v.name, " rf_we outside WB"}, 32'(stray_rf), 32'd0);
      exp_retired++;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int reqc;
      //           name          opc         we3 wem ld tk fw mw sel rf lat dc dwe
      vecs[0]  = '{"op_add",     7'b0110011, 1, 0, 0, 0, 0, 0, 2'd0, 1, 4, 0, 0};
      vecs[1]  = '{"load_w3",    7'b0000011, 1, 0, 1, 0, 0, 3, 2'd0, 1, 8, 4, 0};
      vecs[2]  = '{"store",      7'b0100011, 1, 1, 0, 0, 0, 0, 2'd0, 0, 5, 1, 1};
      vecs[3]  = '{"br_taken",   7'b1100011, 0, 0, 0, 1, 0, 0, 2'd1, 0, 4, 0, 0};
      vecs[4]  = '{"br_nottaken",7'b1100011, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4, 0, 0};
      vecs[5]  = '{"jalr",       7'b1100111, 1, 0, 0, 0, 0, 0, 2'd2, 1, 4, 0, 0};
      vecs[6]  = '{"jal",        7'b1101111, 1, 0, 0, 0, 0, 0, 2'd1, 1, 4, 0, 0};
      vecs[7]  = '{"opimm_fw2",  7'b0010011, 1, 0, 0, 0, 2, 0, 2'd0, 1, 6, 0, 0};
      vecs[8]  = '{"fence",      7'b0001111, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4, 0, 0};
      vecs[9]  = '{"lui_tk",     7'b0110111, 1, 0, 0, 1, 0, 0, 2'd0, 1, 4, 0, 0};
      vecs[10] = '{"store_w2",   7'b0100011, 0, 1, 0, 0, 0, 2, 2'd0, 0, 7, 3, 1};
      vecs[11] = '{"auipc_fw3",  7'b0010111, 1, 0, 0, 0, 3, 0, 2'd0, 1, 7, 0, 0};

      do_reset();
      #1;
      check("reset imem_req", 32'(imem_req), 32'd1);
      check("reset dmem_req", 32'(dmem_req), 32'd0);
      check("reset halted", 32'(halted), 32'd0);
      check("reset trap_cause", 32'(trap_cause), 32'd0);
      check("reset retired", retired, 32'd0);
      check("reset pc_we", 32'(pc_we), 32'd0);
      check("reset rf_we", 32'(rf_we), 32'd0);
      check("reset pc_sel", 32'(pc_sel), 32'd0);
      check("reset ir_we", 32'(ir_we), 32'd0);
      @(negedge clk);
      do_reset();

      foreach (vecs[i]) run_vec(vecs[i]);
      #1;
      check("retired after table", retired, 32'(exp_retired));

      // Fetch never answered: four waits then HALT with a bus timeout.
      do_reset();
      reqc = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (halted) break;
         if (imem_req) reqc++;
         @(negedge clk);
      end
      check("fetch timeout req cycles", 32'(reqc), 32'(TO));
      check("fetch timeout halted", 32'(halted), 32'd1);
      check("fetch timeout cause", 32'(trap_cause), 32'd3);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         imem_ready = 1'b1;
         #1;
         check("halt imem_req", 32'(imem_req), 32'd0);
         check("halt ir_we", 32'(ir_we), 32'd0);
         check("halt cause held", 32'(trap_cause), 32'd3);
      end

      // Illegal opcode and ECALL traps.
      for (int k = 0; k < 2; k++) begin
         do_reset();
         opcode = (k == 0) ? 7'b1111111 : 7'b1110011;
         imem_ready = 1'b1;
         #1;
         check("trap ir_we", 32'(ir_we), 32'd1);
         @(negedge clk);
         imem_ready = 1'b0;
         @(negedge clk);
         #1;
         check("trap halted", 32'(halted), 32'd1);
         check("trap cause", 32'(trap_cause), (k == 0) ? 32'd2 : 32'd1);
         check("trap pc_we", 32'(pc_we), 32'd0);
         check("trap retired", retired, 32'd0);
      end

      // Reset in the middle of a LOAD wait.
      do_reset();
      run_vec(vecs[0]);
      opcode = 7'b0000011; dec_load = 1'b1; dec_we3 = 1'b1; dec_wem = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b0;
      #1;
      @(negedge clk);
      imem_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (dmem_req) break;
         @(negedge clk);
      end
      check("load reaches MEM", 32'(dmem_req), 32'd1);
      @(negedge clk);
      #1;
      check("mem wait dmem_req", 32'(dmem_req), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset in MEM pc_we", 32'(pc_we), 32'd0);
      check("reset in MEM rf_we", 32'(rf_we), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("after reset dmem_req", 32'(dmem_req), 32'd0);
      check("after reset imem_req", 32'(imem_req), 32'd1);
      check("after reset retired", retired, 32'd0);
      check("after reset pc_we", 32'(pc_we), 32'd0);

      // Data access never answered: four MEM waits then HALT cause 3.
      do_reset();
      opcode = 7'b0000011; dec_load = 1'b1; dec_we3 = 1'b1; dec_wem = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b0;
      #1;
      @(negedge clk);
      imem_ready = 1'b0;
      reqc = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (halted) break;
         if (dmem_req) reqc++;
         check("mem timeout no rf_we", 32'(rf_we), 32'd0);
         @(negedge clk);
      end
      check("mem timeout req cycles", 32'(reqc), 32'(TO));
      check("mem timeout cause", 32'(trap_cause), 32'd3);
      check("mem timeout dmem_req", 32'(dmem_req), 32'd0);

      @(negedge clk);
      do_reset();
      #1;
      check("reset clears halted", 32'(halted), 32'd0);
      check("reset clears cause", 32'(trap_cause), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
